// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address receiver: decodes sampled pins, tracks per-bank open state,
// captures MRS timing parameters and produces read/write data windows.
module ddr4_cmd_decoder #(
    parameter int NUM_BANKS   = 16,
    parameter int ROW_W       = 14,
    parameter int SCHED_DEPTH = 32
) (
    input  logic                   CK_t,
    input  logic                   reset_n,
    input  logic                   cs_n,
    input  logic                   act_n,
    input  logic                   RAS_n_A16,
    input  logic                   CAS_n_A15,
    input  logic                   WE_n_A14,
    input  logic [1:0]             bg_addr,
    input  logic [1:0]             ba_addr,
    input  logic                   A17,
    input  logic                   A13,
    input  logic                   A12_BC_n,
    input  logic                   A11,
    input  logic                   A10_AP,
    input  logic [9:0]             A9_A0,
    output logic                   cmd_valid,
    output logic [3:0]             cmd_code,
    output logic [3:0]             cmd_bank,
    output logic [ROW_W-1:0]       cmd_row,
    output logic [9:0]             cmd_col,
    output logic [NUM_BANKS-1:0]   bank_open,
    output logic [4:0]             CL,
    output logic [4:0]             AL,
    output logic [4:0]             CWL,
    output logic [4:0]             BL,
    output logic                   rd_data_en,
    output logic                   wr_data_en,
    output logic                   protocol_err
);

    localparam logic [3:0] C_DES  = 4'd0;
    localparam logic [3:0] C_NOP  = 4'd1;
    localparam logic [3:0] C_ACT  = 4'd2;
    localparam logic [3:0] C_RD   = 4'd3;
    localparam logic [3:0] C_RDA  = 4'd4;
    localparam logic [3:0] C_WR   = 4'd5;
    localparam logic [3:0] C_WRA  = 4'd6;
    localparam logic [3:0] C_PRE  = 4'd7;
    localparam logic [3:0] C_PREA = 4'd8;
    localparam logic [3:0] C_REF  = 4'd9;
    localparam logic [3:0] C_MRS  = 4'd10;
    localparam logic [3:0] C_ZQCL = 4'd11;
    localparam logic [3:0] C_ZQCS = 4'd12;
    localparam logic [3:0] C_RFU  = 4'd15;

    logic                   r_cmd_valid;
    logic [3:0]             r_cmd_code;
    logic [3:0]             r_cmd_bank;
    logic [ROW_W-1:0]       r_cmd_row;
    logic [9:0]             r_cmd_col;
    logic                   r_err;
    logic [NUM_BANKS-1:0]   r_bank_open;
    logic [ROW_W-1:0]       r_row_tbl [NUM_BANKS];
    logic [4:0]             r_cl, r_al, r_cwl, r_bl;
    logic [SCHED_DEPTH-1:0] r_rd_sr, r_wr_sr;

    logic [3:0]             w_code;
    logic [3:0]             w_bank;
    logic [ROW_W-1:0]       w_row;
    logic                   w_open;
    logic                   w_err;
    logic                   w_is_rd;
    logic                   w_is_wr;
    logic [5:0]             w_rl, w_wl;
    logic [SCHED_DEPTH-1:0] w_burst;
    logic [SCHED_DEPTH-1:0] w_rd_next, w_wr_next;
    logic                   w_unused;

    assign w_bank = {bg_addr, ba_addr};
    assign w_row  = {A13, A12_BC_n, A11, A10_AP, A9_A0};
    assign w_open = r_bank_open[w_bank];
    // Stored rows are consumed only by the surrounding memory model; A17 is a don't-care.
    assign w_unused = A17 ^ (^r_row_tbl[w_bank]);

    // Pin-level command decode.
    always_comb begin
        w_code = C_DES;
        if (cs_n) begin
            w_code = C_DES;
        end else if (!act_n) begin
            w_code = C_ACT;
        end else begin
            case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
                3'b000:  w_code = C_MRS;
                3'b001:  w_code = C_REF;
                3'b010:  w_code = A10_AP ? C_PREA : C_PRE;
                3'b011:  w_code = C_RFU;
                3'b100:  w_code = A10_AP ? C_WRA : C_WR;
                3'b101:  w_code = A10_AP ? C_RDA : C_RD;
                3'b110:  w_code = A10_AP ? C_ZQCL : C_ZQCS;
                3'b111:  w_code = C_NOP;
                default: w_code = C_NOP;
            endcase
        end
    end

    // Illegal command detection and burst window scheduling.
    always_comb begin
        w_err = 1'b0;
        case (w_code)
            C_ACT:                        w_err = w_open;
            C_RD, C_RDA, C_WR, C_WRA,
            C_PRE:                        w_err = !w_open;
            C_REF, C_MRS:                 w_err = |r_bank_open;
            C_RFU:                        w_err = 1'b1;
            default:                      w_err = 1'b0;
        endcase
        w_is_rd = ((w_code == C_RD) || (w_code == C_RDA)) && !w_err;
        w_is_wr = ((w_code == C_WR) || (w_code == C_WRA)) && !w_err;
        w_rl    = {1'b0, r_al} + {1'b0, r_cl};
        w_wl    = {1'b0, r_al} + {1'b0, r_cwl};
        if (r_bl == 5'd4) begin
            w_burst = SCHED_DEPTH'(4'h3);
        end else begin
            w_burst = SCHED_DEPTH'(4'hF);
        end
        w_rd_next = (r_rd_sr >> 1) | (w_is_rd ? (w_burst << w_rl) : {SCHED_DEPTH{1'b0}});
        w_wr_next = (r_wr_sr >> 1) | (w_is_wr ? (w_burst << w_wl) : {SCHED_DEPTH{1'b0}});
    end

    // Registered decode outputs.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= C_DES;
            r_cmd_bank  <= 4'd0;
            r_cmd_row   <= {ROW_W{1'b0}};
            r_cmd_col   <= 10'd0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= (w_code != C_DES) && (w_code != C_NOP);
            r_cmd_code  <= w_code;
            r_cmd_bank  <= w_bank;
            r_cmd_row   <= (w_code == C_ACT) ? w_row : {ROW_W{1'b0}};
            r_cmd_col   <= ((w_code == C_RD) || (w_code == C_RDA) ||
                            (w_code == C_WR) || (w_code == C_WRA)) ? A9_A0 : 10'd0;
            r_err       <= w_err;
        end
    end

    // Bank table; auto-precharge closes the bank on the same edge the burst is scheduled.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_open <= {NUM_BANKS{1'b0}};
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_row_tbl[i] <= {ROW_W{1'b0}};
            end
        end else if (!w_err) begin
            case (w_code)
                C_ACT: begin
                    r_bank_open[w_bank] <= 1'b1;
                    r_row_tbl[w_bank]   <= w_row;
                end
                C_PRE, C_RDA, C_WRA: r_bank_open[w_bank] <= 1'b0;
                C_PREA:              r_bank_open <= {NUM_BANKS{1'b0}};
                default:             r_bank_open <= r_bank_open;
            endcase
        end else begin
            r_bank_open <= r_bank_open;
        end
    end

    // Mode register capture; MR1 derives AL from the CL currently in force.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_cl  <= 5'd9;
            r_al  <= 5'd0;
            r_cwl <= 5'd9;
            r_bl  <= 5'd8;
        end else if ((w_code == C_MRS) && !w_err) begin
            case ({bg_addr[0], ba_addr})
                3'd0: begin
                    if (A9_A0[6:3] < 4'd4) begin
                        r_cl <= 5'd9 + {3'b000, A9_A0[4:3]};
                    end else begin
                        r_cl <= 5'd9;
                    end
                    r_bl <= (A9_A0[1:0] == 2'b10) ? 5'd4 : 5'd8;
                end
                3'd1: begin
                    if ((A9_A0[4:3] == 2'b01) || (A9_A0[4:3] == 2'b10)) begin
                        r_al <= r_cl - {3'b000, A9_A0[4:3]};
                    end else begin
                        r_al <= 5'd0;
                    end
                end
                3'd2: begin
                    if ((A9_A0[5:3] == 3'd0) || (A9_A0[5:3] == 3'd2)) begin
                        r_cwl <= 5'd9 + {2'b00, A9_A0[5:3]};
                    end else begin
                        r_cwl <= 5'd9;
                    end
                end
                default: r_cl <= r_cl;
            endcase
        end else begin
            r_cl <= r_cl;
        end
    end

    // Data window shift registers; bit 0 is the live enable.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sr <= {SCHED_DEPTH{1'b0}};
            r_wr_sr <= {SCHED_DEPTH{1'b0}};
        end else begin
            r_rd_sr <= w_rd_next;
            r_wr_sr <= w_wr_next;
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_code     = r_cmd_code;
    assign cmd_bank     = r_cmd_bank;
    assign cmd_row      = r_cmd_row;
    assign cmd_col      = r_cmd_col;
    assign bank_open    = r_bank_open;
    assign CL           = r_cl;
    assign AL           = r_al;
    assign CWL          = r_cwl;
    assign BL           = r_bl;
    assign rd_data_en   = r_rd_sr[0];
    assign wr_data_en   = r_wr_sr[0];
    assign protocol_err = r_err;

endmodule
